// File: rtl/uart_core_param_if.sv
// uart_core_param_if
//   Bus-side bundle of the parametrised UART core. The serial pins (rx/tx)
//   and clk/rst stay plain ports on the core; everything the system bus
//   logic touches lives here.
//   master : bus logic (drives dintx/newd, observes status and RX data)
//   slave  : UART core
//   Signals: dintx/newd (TX request), tx_busy/donetx (TX status),
//            doutrx/donerx/parity_err/frame_err/rx_break (RX results).
interface uart_core_param_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] dintx;
  logic                 newd;
  logic                 tx_busy;
  logic                 donetx;
  logic [DATA_BITS-1:0] doutrx;
  logic                 donerx;
  logic                 parity_err;
  logic                 frame_err;
  logic                 rx_break;

  modport master (
    output dintx, newd,
    input  tx_busy, donetx, doutrx, donerx, parity_err, frame_err, rx_break
  );

  modport slave (
    input  dintx, newd,
    output tx_busy, donetx, doutrx, donerx, parity_err, frame_err, rx_break
  );
endinterface

// File: rtl/uart_core_param.sv
// uart_core_param
//   Parametrised full-duplex UART core (data width, parity, stop bits,
//   baud divisor). Single clock domain; every bit lasts CLKS_PER_BIT clocks.
//   RX samples mid-bit, rejects start glitches and flags parity/framing
//   errors.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous reset, active-high
//   rx   - serial line in (asynchronous, synchronised internally)
//   tx   - serial line out, idle high
//   bus  - uart_core_param_if.slave: dintx/newd request, tx_busy/donetx,
//          doutrx/donerx, parity_err, frame_err, rx_break
// Optional feature:
//   UART_BREAK_DETECT_EN - when defined, an all-zero frame (start, data,
//   parity, first stop) pulses rx_break with donerx, and RX waits for the
//   line to be high for one full bit time before re-arming. When undefined
//   rx_break is tied 0.
module uart_core_param #(
  parameter int CLK_FREQ    = 1000000,
  parameter int BAUD        = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic               tx,
  uart_core_param_if.slave   bus
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(STOP_CLKS + 1);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [CNT_W-1:0] STOP_PRE  = CNT_W'(STOP_CLKS - 2);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  // Even mode: XOR of the data. Odd mode: its inverse.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == 2) ? ~(^d) : (^d);
  endfunction

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

  tx_state_t            tx_state_reg;
  logic [CNT_W-1:0]     tx_cnt_reg;
  logic [IDX_W-1:0]     tx_idx_reg;
  logic [DATA_BITS-1:0] tx_shift_reg;
  logic                 tx_par_reg;
  logic                 tx_reg;
  logic                 tx_busy_reg;
  logic                 donetx_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_idx_reg   <= '0;
      tx_shift_reg <= '0;
      tx_par_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      tx_busy_reg  <= 1'b0;
      donetx_reg   <= 1'b0;
    end else begin
      donetx_reg <= 1'b0;
      case (tx_state_reg)
        TX_IDLE: begin
          tx_reg <= 1'b1;
          if (bus.newd) begin
            tx_shift_reg <= bus.dintx;
            tx_par_reg   <= parity_of(bus.dintx);
            tx_reg       <= 1'b0;
            tx_busy_reg  <= 1'b1;
            tx_cnt_reg   <= '0;
            tx_state_reg <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_idx_reg   <= '0;
            tx_reg       <= tx_shift_reg[0];
            tx_state_reg <= TX_DATA;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg <= '0;
            if (tx_idx_reg == IDX_LAST) begin
              if (PARITY_MODE != 0) begin
                tx_reg       <= tx_par_reg;
                tx_state_reg <= TX_PARITY;
              end else begin
                tx_reg       <= 1'b1;
                tx_state_reg <= TX_STOP;
              end
            end else begin
              // Shift register keeps the next bit at index 1.
              tx_idx_reg   <= tx_idx_reg + IDX_ONE;
              tx_shift_reg <= tx_shift_reg >> 1;
              tx_reg       <= tx_shift_reg[1];
            end
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
          end
        end
        TX_PARITY: begin
          if (tx_cnt_reg == BIT_LAST) begin
            tx_cnt_reg   <= '0;
            tx_reg       <= 1'b1;
            tx_state_reg <= TX_STOP;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
          end
        end
        TX_STOP: begin
          // donetx/tx_busy are registered one clock early so they are
          // visible during the last stop clock; the state stays in STOP
          // for that clock so a newd there is ignored.
          if (tx_cnt_reg == STOP_LAST) begin
            tx_cnt_reg   <= '0;
            tx_state_reg <= TX_IDLE;
          end else begin
            tx_cnt_reg <= tx_cnt_reg + CNT_ONE;
            if (tx_cnt_reg == STOP_PRE) begin
              donetx_reg  <= 1'b1;
              tx_busy_reg <= 1'b0;
            end
          end
        end
        default: tx_state_reg <= TX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
`ifdef UART_BREAK_DETECT_EN
    , RX_BREAK_WAIT
`endif
  } rx_state_t;

  logic [1:0]           sync_reg;
  logic                 rx_sync;
  logic                 rx_prev_reg;
  rx_state_t            rx_state_reg;
  logic [CNT_W-1:0]     rx_cnt_reg;
  logic [IDX_W-1:0]     rx_idx_reg;
  logic [DATA_BITS-1:0] rx_shift_reg;
  logic                 rx_par_reg;
  logic [DATA_BITS-1:0] doutrx_reg;
  logic                 donerx_reg;
  logic                 parity_err_reg;
  logic                 frame_err_reg;
`ifdef UART_BREAK_DETECT_EN
  logic                 rx_break_reg;
`endif

  assign rx_sync = sync_reg[1];

  // Two-flop synchroniser, idle-high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_prev_reg    <= 1'b1;
      rx_state_reg   <= RX_IDLE;
      rx_cnt_reg     <= '0;
      rx_idx_reg     <= '0;
      rx_shift_reg   <= '0;
      rx_par_reg     <= 1'b0;
      doutrx_reg     <= '0;
      donerx_reg     <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      rx_break_reg   <= 1'b0;
`endif
    end else begin
      rx_prev_reg <= rx_sync;
      donerx_reg  <= 1'b0;
`ifdef UART_BREAK_DETECT_EN
      rx_break_reg <= 1'b0;
`endif
      case (rx_state_reg)
        RX_IDLE: begin
          // Edge (not level) detect: after a frame whose stop bit read 0
          // the line may still be low and must not retrigger.
          if (rx_prev_reg && !rx_sync) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt_reg == HALF_LAST) begin
            rx_cnt_reg   <= '0;
            rx_idx_reg   <= '0;
            rx_state_reg <= rx_sync ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_shift_reg <= {rx_sync, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_idx_reg == IDX_LAST) begin
              rx_state_reg <= (PARITY_MODE != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx_reg <= rx_idx_reg + IDX_ONE;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        RX_PARITY: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_par_reg   <= rx_sync;
            rx_state_reg <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg     <= '0;
            doutrx_reg     <= rx_shift_reg;
            parity_err_reg <= (PARITY_MODE != 0) && (rx_par_reg != parity_of(rx_shift_reg));
            frame_err_reg  <= ~rx_sync;
            donerx_reg     <= 1'b1;
            rx_state_reg   <= RX_IDLE;
`ifdef UART_BREAK_DETECT_EN
            if ((rx_shift_reg == '0) && !rx_sync && ((PARITY_MODE == 0) || !rx_par_reg)) begin
              rx_break_reg <= 1'b1;
              rx_state_reg <= RX_BREAK_WAIT;
            end
`endif
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
`ifdef UART_BREAK_DETECT_EN
        RX_BREAK_WAIT: begin
          // Re-arm only after one unbroken bit time of idle-high line.
          if (!rx_sync) begin
            rx_cnt_reg <= '0;
          end else if (rx_cnt_reg == BIT_LAST) begin
            rx_cnt_reg   <= '0;
            rx_state_reg <= RX_IDLE;
          end else begin
            rx_cnt_reg <= rx_cnt_reg + CNT_ONE;
          end
        end
`endif
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  assign tx             = tx_reg;
  assign bus.tx_busy    = tx_busy_reg;
  assign bus.donetx     = donetx_reg;
  assign bus.doutrx     = doutrx_reg;
  assign bus.donerx     = donerx_reg;
  assign bus.parity_err = parity_err_reg;
  assign bus.frame_err  = frame_err_reg;
`ifdef UART_BREAK_DETECT_EN
  assign bus.rx_break   = rx_break_reg;
`else
  assign bus.rx_break   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: three instances
//   u0: 8N1, 104 clk/bit (defaults), rx driven by the bench
//   u1: 8E1, 16 clk/bit, rx driven by the bench
//   u2: 7O2, 16 clk/bit, tx looped back into its own rx
module tb_uart_core_param;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         newd_r  [N];
  logic [8:0]   dintx_r [N];
  logic         rx0, rx1;
  logic [N-1:0] tx_w, busy_w, donetx_w, donerx_w, perr_w, ferr_w, brk_w;
  logic [8:0]   dout_w  [N];

  uart_core_param_if #(.DATA_BITS(8)) if0 ();
  uart_core_param_if #(.DATA_BITS(8)) if1 ();
  uart_core_param_if #(.DATA_BITS(7)) if2 ();

  assign if0.dintx = dintx_r[0][7:0];
  assign if0.newd  = newd_r[0];
  assign if1.dintx = dintx_r[1][7:0];
  assign if1.newd  = newd_r[1];
  assign if2.dintx = dintx_r[2][6:0];
  assign if2.newd  = newd_r[2];

  assign busy_w   = {if2.tx_busy, if1.tx_busy, if0.tx_busy};
  assign donetx_w = {if2.donetx, if1.donetx, if0.donetx};
  assign donerx_w = {if2.donerx, if1.donerx, if0.donerx};
  assign perr_w   = {if2.parity_err, if1.parity_err, if0.parity_err};
  assign ferr_w   = {if2.frame_err, if1.frame_err, if0.frame_err};
  assign brk_w    = {if2.rx_break, if1.rx_break, if0.rx_break};
  assign dout_w[0] = {1'b0, if0.doutrx};
  assign dout_w[1] = {1'b0, if1.doutrx};
  assign dout_w[2] = {2'b00, if2.doutrx};

  uart_core_param #(.CLK_FREQ(1000000), .BAUD(9600), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1))
    u0 (.clk(clk), .rst(rst), .rx(rx0), .tx(tx_w[0]), .bus(if0));
  uart_core_param #(.CLK_FREQ(160000), .BAUD(10000), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1))
    u1 (.clk(clk), .rst(rst), .rx(rx1), .tx(tx_w[1]), .bus(if1));
  uart_core_param #(.CLK_FREQ(160000), .BAUD(10000), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2))
    u2 (.clk(clk), .rst(rst), .rx(tx_w[2]), .tx(tx_w[2]), .bus(if2));

  // ---------------- reference model (frame format from the rules)
  function automatic int cpb_of(input int i); return (i == 0) ? 104 : 16; endfunction
  function automatic int db_of(input int i);  return (i == 2) ? 7 : 8;    endfunction
  function automatic int pm_of(input int i);  return i;                   endfunction
  function automatic int sb_of(input int i);  return (i == 2) ? 2 : 1;    endfunction
  function automatic int nbits_of(input int i);
    return 1 + db_of(i) + ((pm_of(i) != 0) ? 1 : 0) + sb_of(i);
  endfunction

  function automatic logic par_of(input int i, input logic [8:0] d);
    logic [8:0] m;
    logic       even;
    m    = d & ((9'd1 << db_of(i)) - 9'd1);
    even = (($countones(m) % 2) == 1);
    return (pm_of(i) == 2) ? ~even : even;
  endfunction

  // Expected line level of bit position k of a frame carrying d.
  function automatic logic line_bit(input int i, input logic [8:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= db_of(i)) return d[k-1];
    if (pm_of(i) != 0 && k == db_of(i) + 1) return par_of(i, d);
    return 1'b1;
  endfunction

  // ---------------- bookkeeping
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         inst;
    logic [8:0] dout;
    logic       perr;
    logic       ferr;
    logic       brk;
  } rx_rec_t;

  rx_rec_t rxq[$];
  int      donetx_cnt [N];

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (donerx_w[k]) rxq.push_back('{k, dout_w[k], perr_w[k], ferr_w[k], brk_w[k]});
      if (donetx_w[k]) donetx_cnt[k]++;
    end
  end

  task automatic check_rx(input int i, input logic [8:0] d, input logic pe, input logic fe, input logic bk);
    rx_rec_t r;
    check($sformatf("rx%0d donerx present", i), int'(rxq.size() > 0), 1);
    if (rxq.size() > 0) begin
      r = rxq.pop_front();
      check($sformatf("rx%0d inst", i), r.inst, i);
      check($sformatf("rx%0d doutrx", i), r.dout, d);
      check($sformatf("rx%0d parity_err", i), r.perr, pe);
      check($sformatf("rx%0d frame_err", i), r.ferr, fe);
      check($sformatf("rx%0d rx_break", i), r.brk, bk);
    end
    $display("rx%0d: expect data=%0h perr=%0d ferr=%0d brk=%0d", i, d, pe, fe, bk);
  endtask

  task automatic check_rx_none(input string name);
    check(name, rxq.size(), 0);
    rxq.delete();
  endtask

  // Request a frame at the current negedge and check it cycle by cycle.
  task automatic send_tx(input int i, input logic [8:0] d, input bit renewd);
    int nb, cpb, total, busy_n, done_n, done_at, bad;
    nb = nbits_of(i); cpb = cpb_of(i); total = nb * cpb;
    dintx_r[i] = d; newd_r[i] = 1'b1;
    @(negedge clk);
    newd_r[i] = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int k = 0; k < nb; k++) begin
      bad = 0;
      for (int c = 0; c < cpb; c++) begin
        if (tx_w[i] !== line_bit(i, d, k)) bad++;
        if (busy_w[i]) busy_n++;
        if (donetx_w[i]) begin done_n++; done_at = k * cpb + c; end
        if (renewd && k == 4) begin newd_r[i] = (c == 0); dintx_r[i] = ~d; end
        @(negedge clk);
      end
      check($sformatf("tx%0d bit%0d cycles wrong", i, k), bad, 0);
    end
    check($sformatf("tx%0d busy cycles", i), busy_n, total - 1);
    check($sformatf("tx%0d donetx count", i), done_n, 1);
    check($sformatf("tx%0d donetx position", i), done_at, total - 1);
    check($sformatf("tx%0d idle after frame", i), {tx_w[i], busy_w[i]}, 2'b10);
    $display("tx%0d: data=%0h frame of %0d bits x %0d clks", i, d, nb, cpb);
  endtask

  task automatic set_rx(input int i, input logic v);
    if (i == 0) rx0 = v; else rx1 = v;
  endtask

  task automatic drive_rx(input int i, input logic [8:0] d, input logic pbit, input logic stopv);
    int nb, db, p;
    logic v;
    nb = nbits_of(i); db = db_of(i); p = (pm_of(i) != 0) ? 1 : 0;
    for (int k = 0; k < nb; k++) begin
      if (k == 0) v = 1'b0;
      else if (k <= db) v = d[k-1];
      else if (p == 1 && k == db + 1) v = pbit;
      else if (k == db + 1 + p) v = stopv;
      else v = 1'b1;
      set_rx(i, v);
      repeat (cpb_of(i)) @(negedge clk);
    end
    set_rx(i, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       pbit;
    logic       stopv;
    logic [8:0] exp_dout;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic [8:0] d;
    logic       pb, sv;
    int         cnt_before;

    tbl[0] = '{1, 9'h03C, 1'b0, 1'b1, 9'h03C, 1'b0, 1'b0};
    tbl[1] = '{1, 9'h03C, 1'b1, 1'b1, 9'h03C, 1'b1, 1'b0};
    tbl[2] = '{0, 9'h081, 1'b0, 1'b0, 9'h081, 1'b0, 1'b1};
    tbl[3] = '{1, 9'h001, 1'b1, 1'b1, 9'h001, 1'b0, 1'b0};
    tbl[4] = '{1, 9'h0FF, 1'b0, 1'b0, 9'h0FF, 1'b0, 1'b1};
    tbl[5] = '{0, 9'h000, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};

    for (int k = 0; k < N; k++) begin
      newd_r[k] = 1'b0; dintx_r[k] = '0; donetx_cnt[k] = 0;
    end
    rx0 = 1'b1; rx1 = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset tx", tx_w, 3'b111);
    check("reset tx_busy", busy_w, 0);
    check("reset donetx", donetx_w, 0);
    check("reset donerx", donerx_w, 0);
    check("reset parity_err", perr_w, 0);
    check("reset frame_err", ferr_w, 0);
    check("reset rx_break", brk_w, 0);
    for (int k = 0; k < N; k++) check($sformatf("reset doutrx%0d", k), dout_w[k], 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // 8N1 A5 with a newd re-pulse mid-frame that must be ignored
    send_tx(0, 9'h0A5, 1'b1);
    repeat (20) @(negedge clk);
    check("tx0 no second frame", busy_w[0], 0);

    // Table-driven RX vectors
    for (int v = 0; v < 6; v++) begin
      drive_rx(tbl[v].inst, tbl[v].data, tbl[v].pbit, tbl[v].stopv);
      check_rx(tbl[v].inst, tbl[v].exp_dout, tbl[v].exp_perr, tbl[v].exp_ferr, 1'b0);
      check_rx_none($sformatf("vector %0d single donerx", v));
    end

    // 7O2 back-to-back TX looped into RX
    send_tx(2, 9'h055, 1'b0);
    send_tx(2, 9'h02A, 1'b0);
    repeat (8) @(negedge clk);
    check_rx(2, 9'h055, 1'b0, 1'b0, 1'b0);
    check_rx(2, 9'h02A, 1'b0, 1'b0, 1'b0);
    check_rx_none("loopback pulse count");

    // Start glitch shorter than half a bit: no donerx, RX still usable
    rx0 = 1'b0;
    repeat (30) @(negedge clk);
    rx0 = 1'b1;
    repeat (1200) @(negedge clk);
    check_rx_none("glitch rejected");
    drive_rx(0, 9'h081, 1'b0, 1'b1);
    check_rx(0, 9'h081, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during TX data bit 4
    cnt_before = donetx_cnt[0];
    dintx_r[0] = 9'h0A5; newd_r[0] = 1'b1;
    @(negedge clk);
    newd_r[0] = 1'b0;
    repeat (5 * 104 + 50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async reset tx", tx_w[0], 1);
    check("async reset tx_busy", busy_w[0], 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (1200) @(negedge clk);
    check("no donetx after abort", donetx_cnt[0], cnt_before);
    check_rx_none("no donerx after reset");
    send_tx(0, 9'h03C, 1'b0);

    // Randomised frames against the model
    for (int r = 0; r < 12; r++) begin
      d  = 9'($urandom_range(1, 255));
      pb = 1'($urandom_range(0, 1));
      sv = ($urandom_range(0, 3) != 0);
      drive_rx(1, d, pb, sv);
      check_rx(1, d, (pb != par_of(1, d)), ~sv, 1'b0);
    end
    for (int r = 0; r < 2; r++) send_tx(0, 9'($urandom_range(0, 255)), 1'b0);
    begin
      logic [8:0] a, b;
      a = 9'($urandom_range(0, 127));
      b = 9'($urandom_range(0, 127));
      send_tx(2, a, 1'b0);
      send_tx(2, b, 1'b0);
      repeat (8) @(negedge clk);
      check_rx(2, a, 1'b0, 1'b0, 1'b0);
      check_rx(2, b, 1'b0, 1'b0, 1'b0);
    end
    check_rx_none("random pulse count");

    // Long low line (break) followed by a valid frame
    rx0 = 1'b0;
    repeat (2000) @(negedge clk);
    rx0 = 1'b1;
`ifdef UART_BREAK_DETECT_EN
    // A start-like pulse before the line has idled one bit time is ignored.
    repeat (50) @(negedge clk);
    rx0 = 1'b0;
    repeat (60) @(negedge clk);
    rx0 = 1'b1;
    repeat (300) @(negedge clk);
    check_rx(0, 9'h000, 1'b0, 1'b1, 1'b1);
`else
    repeat (300) @(negedge clk);
    check_rx(0, 9'h000, 1'b0, 1'b1, 1'b0);
`endif
    check_rx_none("break single donerx");
    drive_rx(0, 9'h05A, 1'b0, 1'b1);
    check_rx(0, 9'h05A, 1'b0, 1'b0, 1'b0);
    check_rx_none("after break pulse count");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
